// File: rtl/rps_rr_arbiter.sv
// rps_rr_arbiter
//   N-way rotating-priority arbiter with an optional grant lock.
//   The grant is combinational. The priority pointer and the lock state
//   are registered.
//   MODE 0: the pointer advances every cycle while arbitrating.
//   MODE 1: round-robin. The pointer moves to one past the last winner.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous, active-low reset
//   req        request vector, bit i = requester i
//   en         arbiter enable; 0 forces the grant to zero
//   lock_req   sampled at the edge; the current winner keeps the grant
//   gnt        one-hot or zero grant
//   gnt_valid  |gnt
//   gnt_idx    encoded index of the granted bit, 0 when nothing is granted
//   count      current priority pointer
//   locked     1 while a requester owns the grant
module rps_rr_arbiter #(
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             lock_req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [IDX_W-1:0] count,
  output logic             locked
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] scan_idx;
  logic             found;

  // Reset gates the grant as well, so the outputs go quiet as soon as
  // reset_n falls, without waiting for the registers.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = '0;
    if (reset_n && en) begin
      if (state == LOCKED) begin
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          gnt_idx    = owner;
        end
      end else begin
        // Scan from the pointer upward. IDX_W-bit addition wraps modulo N.
        for (int k = 0; k < N; k++) begin
          scan_idx = count + IDX_W'(k);
          if (!found && req[scan_idx]) begin
            found         = 1'b1;
            gnt[scan_idx] = 1'b1;
            gnt_idx       = scan_idx;
          end
        end
      end
    end
  end

  assign gnt_valid = |gnt;
  assign locked    = (state == LOCKED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
      owner <= '0;
      count <= '0;
    end else begin
      case (state)
        ARB: begin
          if (en && gnt_valid && lock_req) begin
            state <= LOCKED;
            owner <= gnt_idx;
          end
          // MODE 0 keeps the free-running pointer of the older selector.
          if (MODE == 0) begin
            count <= count + IDX_W'(1);
          end else if (en && gnt_valid) begin
            count <= gnt_idx + IDX_W'(1);
          end
        end
        LOCKED: begin
          // The pointer stays frozen while locked. On release, MODE 1
          // skips past the owner so that the owner does not win again at once.
          if (!req[owner] || !lock_req) begin
            state <= ARB;
            if (MODE != 0) begin
              count <= owner + IDX_W'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_rr_arbiter.sv
// tb_rps_rr_arbiter
//   Three instances: N=4 MODE 0 (sel 0), N=4 MODE 1 (sel 1), and
//   N=8 MODE 1 (sel 2). The bench pushes expected outputs to a scoreboard
//   queue when it drives stimulus. A negedge monitor pops each entry and
//   compares it against the selected instance.
module tb_rps_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       en;
  logic       lock_req;

  logic [3:0] gnt0, gnt1;
  logic [7:0] gnt2;
  logic       v0, v1, v2;
  logic [1:0] idx0, idx1, cnt0, cnt1;
  logic [2:0] idx2, cnt2;
  logic       lk0, lk1, lk2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    string      tag;
    logic [7:0] g;
    logic [2:0] idx;
    logic [2:0] cnt;
    logic       lk;
  } exp_t;

  exp_t sb[$];

  // Reference model state for the random phase (index 0 = MODE 0, 1 = MODE 1)
  logic [1:0] m_cnt [2];
  logic       m_lock[2];
  logic [1:0] m_own [2];

  rps_rr_arbiter #(.N(4), .MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req[3:0]), .en(en), .lock_req(lock_req),
    .gnt(gnt0), .gnt_valid(v0), .gnt_idx(idx0), .count(cnt0), .locked(lk0));

  rps_rr_arbiter #(.N(4), .MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req[3:0]), .en(en), .lock_req(lock_req),
    .gnt(gnt1), .gnt_valid(v1), .gnt_idx(idx1), .count(cnt1), .locked(lk1));

  rps_rr_arbiter #(.N(8), .MODE(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .req(req), .en(en), .lock_req(lock_req),
    .gnt(gnt2), .gnt_valid(v2), .gnt_idx(idx2), .count(cnt2), .locked(lk2));

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor, sampling away from the rising edge
  always @(negedge clock) begin : monitor
    exp_t       e;
    logic [7:0] a_g;
    logic [2:0] a_i, a_c;
    logic       a_v, a_l;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin a_g = {4'b0, gnt0}; a_i = {1'b0, idx0}; a_c = {1'b0, cnt0}; a_v = v0; a_l = lk0; end
        1:       begin a_g = {4'b0, gnt1}; a_i = {1'b0, idx1}; a_c = {1'b0, cnt1}; a_v = v1; a_l = lk1; end
        default: begin a_g = gnt2;         a_i = idx2;         a_c = cnt2;         a_v = v2; a_l = lk2; end
      endcase
      check_output({e.tag, ".gnt"},       32'(a_g), 32'(e.g));
      check_output({e.tag, ".gnt_idx"},   32'(a_i), 32'(e.idx));
      check_output({e.tag, ".count"},     32'(a_c), 32'(e.cnt));
      check_output({e.tag, ".locked"},    32'(a_l), 32'(e.lk));
      check_output({e.tag, ".gnt_valid"}, 32'(a_v), 32'(|e.g));
    end
  end

  task automatic push_exp(input int sel, input string tag, input logic [7:0] g,
                          input logic [2:0] idx, input logic [2:0] cnt, input logic lk);
    exp_t e;
    e.sel = sel; e.tag = tag; e.g = g; e.idx = idx; e.cnt = cnt; e.lk = lk;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, and advance to posedge+1.
  task automatic apply_stimulus(input int sel, input string tag, input logic [7:0] r,
                                input logic e, input logic l, input logic [7:0] g,
                                input logic [2:0] idx, input logic [2:0] cnt, input logic lk);
    req = r; en = e; lock_req = l;
    push_exp(sel, tag, g, idx, cnt, lk);
    @(posedge clock); #1;
  endtask

  // Hold reset across one edge, check outputs under reset with busy inputs, then release.
  task automatic reset_all();
    reset_n = 1'b0; req = '0; en = 1'b0; lock_req = 1'b0;
    @(posedge clock); #1;
    req = 8'hff; en = 1'b1; lock_req = 1'b1;
    #1;
    check_output("rst.gnt",       32'(gnt1), 32'h0);
    check_output("rst.gnt_valid", 32'(v1),   32'h0);
    check_output("rst.gnt_idx",   32'(idx1), 32'h0);
    check_output("rst.count",     32'(cnt0), 32'h0);
    check_output("rst.locked",    32'(lk1),  32'h0);
    reset_n = 1'b1;
  endtask

  task automatic model_eval(input int m, input logic [3:0] r, input logic e,
                            output logic [7:0] g, output logic [2:0] gi);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] w;
    g = '0; gi = '0;
    if (e) begin
      if (m_lock[m]) begin
        if (r[m_own[m]]) begin
          g  = 8'(1) << m_own[m];
          gi = {1'b0, m_own[m]};
        end
      end else begin
        dbl = {r, r};
        rot = 4'(dbl >> m_cnt[m]);
        for (int p = 0; p < 4; p++) begin
          if (rot[p]) begin
            w  = m_cnt[m] + 2'(p);
            g  = 8'(1) << w;
            gi = {1'b0, w};
            break;
          end
        end
      end
    end
  endtask

  task automatic model_update(input int m, input logic [3:0] r, input logic e,
                              input logic l, input logic [7:0] g, input logic [2:0] gi);
    if (!m_lock[m]) begin
      if (e && g != 0 && l) begin
        m_lock[m] = 1'b1;
        m_own[m]  = gi[1:0];
      end
      if (m == 0) m_cnt[m] = m_cnt[m] + 2'd1;
      else if (e && g != 0) m_cnt[m] = gi[1:0] + 2'd1;
    end else if (!r[m_own[m]] || !l) begin
      m_lock[m] = 1'b0;
      if (m == 1) m_cnt[m] = m_own[m] + 2'd1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] r;
    logic       e, l;
    logic [7:0] g [2];
    logic [2:0] gi[2];

    // MODE 0 free-running rotation, wrap-around and enable
    reset_all();
    apply_stimulus(0, "m0_c0", 8'h0f, 1, 0, 8'h01, 0, 0, 0);
    apply_stimulus(0, "m0_c1", 8'h0f, 1, 0, 8'h02, 1, 1, 0);
    apply_stimulus(0, "m0_c2", 8'h0f, 1, 0, 8'h04, 2, 2, 0);
    apply_stimulus(0, "m0_c3", 8'h0f, 1, 0, 8'h08, 3, 3, 0);
    apply_stimulus(0, "m0_c0b", 8'h0f, 1, 0, 8'h01, 0, 0, 0);
    apply_stimulus(0, "m0_en0a", 8'h0f, 0, 0, 8'h00, 0, 1, 0);
    apply_stimulus(0, "m0_p2", 8'h05, 1, 0, 8'h04, 2, 2, 0);
    apply_stimulus(0, "m0_wrap", 8'h05, 1, 0, 8'h01, 0, 3, 0);
    apply_stimulus(0, "m0_en0b", 8'h0f, 0, 0, 8'h00, 0, 0, 0);
    apply_stimulus(0, "m0_en0c", 8'h0f, 0, 0, 8'h00, 0, 1, 0);

    // MODE 1 round-robin, N=4
    reset_all();
    apply_stimulus(1, "m1_a", 8'h0a, 1, 0, 8'h02, 1, 0, 0);
    apply_stimulus(1, "m1_b", 8'h0a, 1, 0, 8'h08, 3, 2, 0);
    apply_stimulus(1, "m1_c", 8'h0a, 1, 0, 8'h02, 1, 0, 0);
    apply_stimulus(1, "m1_en0a", 8'h0a, 0, 0, 8'h00, 0, 2, 0);
    apply_stimulus(1, "m1_en0b", 8'h0a, 0, 0, 8'h00, 0, 2, 0);
    apply_stimulus(1, "m1_d", 8'h0a, 1, 0, 8'h08, 3, 2, 0);

    // MODE 1 round-robin, N=8, extreme indices
    reset_all();
    apply_stimulus(2, "n8_a", 8'h81, 1, 0, 8'h01, 0, 0, 0);
    apply_stimulus(2, "n8_b", 8'h81, 1, 0, 8'h80, 7, 1, 0);
    apply_stimulus(2, "n8_c", 8'h81, 1, 0, 8'h01, 0, 0, 0);
    apply_stimulus(2, "n8_d", 8'h81, 1, 0, 8'h80, 7, 1, 0);

    // Lock handshake, MODE 1
    reset_all();
    apply_stimulus(1, "lk_entry", 8'h04, 1, 1, 8'h04, 2, 0, 0);
    apply_stimulus(1, "lk_hold1", 8'h0f, 1, 1, 8'h04, 2, 3, 1);
    apply_stimulus(1, "lk_hold2", 8'h0f, 1, 1, 8'h04, 2, 3, 1);
    apply_stimulus(1, "lk_en0",   8'h0f, 0, 1, 8'h00, 0, 3, 1);
    apply_stimulus(1, "lk_hold3", 8'h0f, 1, 1, 8'h04, 2, 3, 1);
    apply_stimulus(1, "lk_drop",  8'h0b, 1, 1, 8'h00, 0, 3, 1);
    apply_stimulus(1, "lk_after", 8'h0f, 1, 0, 8'h08, 3, 3, 0);
    apply_stimulus(1, "lk_next",  8'h0f, 1, 0, 8'h01, 0, 0, 0);
    apply_stimulus(1, "lk_noreq", 8'h00, 1, 1, 8'h00, 0, 1, 0);
    apply_stimulus(1, "lk_none",  8'h00, 1, 0, 8'h00, 0, 1, 0);

    // Asynchronous reset in the middle of a lock
    reset_all();
    apply_stimulus(1, "ar_entry", 8'h04, 1, 1, 8'h04, 2, 0, 0);
    req = 8'h0f;
    #1;
    check_output("ar_pre.locked", 32'(lk1),  32'h1);
    check_output("ar_pre.gnt",    32'(gnt1), 32'h4);
    reset_n = 1'b0;
    #1;
    check_output("ar_now.locked",    32'(lk1),  32'h0);
    check_output("ar_now.count",     32'(cnt1), 32'h0);
    check_output("ar_now.gnt",       32'(gnt1), 32'h0);
    check_output("ar_now.gnt_valid", 32'(v1),   32'h0);
    check_output("ar_now.gnt_idx",   32'(idx1), 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    apply_stimulus(1, "ar_after", 8'h0f, 1, 0, 8'h01, 0, 0, 0);

    // Random traffic on both N=4 instances against the reference model
    reset_all();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = '0; m_lock[m] = 1'b0; m_own[m] = '0;
    end
    for (int c = 0; c < 300; c++) begin
      r = 4'($urandom);
      e = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 9) < 7);
      req = {4'b0, r}; en = e; lock_req = l;
      for (int m = 0; m < 2; m++) begin
        model_eval(m, r, e, g[m], gi[m]);
        push_exp(m, $sformatf("rnd%0d_m%0d", c, m), g[m], gi[m], {1'b0, m_cnt[m]}, m_lock[m]);
      end
      @(posedge clock); #1;
      for (int m = 0; m < 2; m++) model_update(m, r, e, l, g[m], gi[m]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rps_rr_arbiter.md
Name: rps_rr_arbiter

Overview:
Parametrised N-way rotating-priority arbiter. Successor to the fixed 4-input rotating priority selector.
- Grant stays combinational (same-cycle); priority pointer is registered.
- MODE 0: free-running rotation. MODE 1: true round-robin, pointer moves to one past the last winner.
- Adds a grant-lock handshake for multi-cycle ownership.
- Sits in front of shared resources (issue ports, CDB, memory bus) in the pipeline.

Parameters:
N, 4, requester count; power of two, 2..32.
MODE, 0, 0 = pointer rotates every cycle; 1 = pointer advances past last granted index.
IDX_W, $clog2(N), width of index/pointer outputs (derived; do not override).

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  N  request vector, bit i = requester i.
en  in  1  arbiter enable; 0 forces gnt to all zeros.
lock_req  in  1  sampled at the edge: winner keeps the grant on following cycles.
gnt  out  N  one-hot or zero grant, combinational.
gnt_valid  out  1  |gnt.
gnt_idx  out  IDX_W  encoded index of the granted bit; 0 when gnt_valid=0.
count  out  IDX_W  current priority pointer.
locked  out  1  1 while in state LOCKED.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - count=0, state=ARB, owner=0, locked=0.
  - gnt=0, gnt_valid=0, gnt_idx=0 while reset_n is low, regardless of req and en.
- Grant search in state ARB:
  - If en=0, then gnt=0.
  - Otherwise scan indices count, count+1, ..., count+N-1 (mod N). First i with req[i]=1 wins; gnt has exactly that bit set.
  - If req=0, then gnt=0.
- State machine, updated at the rising edge:
  - ARB -> LOCKED when en=1, gnt_valid=1 and lock_req=1. owner<=gnt_idx.
  - LOCKED: gnt=onehot(owner) iff en=1 and req[owner]=1, else 0. Other requesters are ignored.
  - LOCKED -> ARB at the edge when req[owner]=0 or lock_req=0. The cycle in which req[owner] is low grants nothing.
  - LOCKED with en=0: gnt=0; state stays LOCKED unless the exit condition holds.
- Pointer update, rising edge:
  - MODE 0, ARB: count<=count+1 mod N every cycle, independent of en and req (legacy counter behaviour).
  - MODE 1, ARB: if en=1 and gnt_valid=1, count<=gnt_idx+1 mod N; otherwise hold.
  - LOCKED, both modes: count frozen.
  - Edge leaving LOCKED: MODE 1 sets count<=owner+1 mod N; MODE 0 resumes incrementing from the frozen value.
- Wrap-around: all pointer arithmetic is modulo N, IDX_W bits; natural overflow is correct since N is a power of two.
- Simultaneous events: lock_req high in the same cycle as the lock-entry grant is the normal entry. lock_req toggling while in ARB with no grant has no effect.
- Reset asserted mid-lock: lock is released immediately; the first cycle after deassertion arbitrates from count=0.
- No X propagation: gnt_idx is 0 whenever gnt=0.

Test Plan:
1. MODE 0, N=4: reset, then en=1, req=1111 for 5 cycles -> gnt 0001, 0010, 0100, 1000, 0001; count 0, 1, 2, 3, 0.
2. MODE 0, N=4, count=3, req=0101 -> gnt=0001 (scan 3->0 wraps); count=2, req=0101 -> gnt=0100. With en=0 and req=1111 -> gnt=0000, count still increments.
3. MODE 1, N=4, from reset, req=1010 held -> gnt 0010 (count->2), 1000 (count->0), 0010. With en=0 -> gnt=0000, count held.
4. MODE 1, N=8, req=8'h81 held -> gnt alternates 8'h01, 8'h80; count alternates 1, 0; gnt_idx alternates 0, 7.
5. Lock, MODE 1, N=4: req=0100, lock_req=1 -> locked=1 next cycle, owner=2. Then req=1111 for 3 cycles -> gnt=0100 each cycle, count frozen. Drop req[2] -> gnt=0000 that cycle, locked=0 next, count=3, next gnt=1000.
6. Async reset while locked=1, between clock edges -> locked, count, gnt all 0 immediately. Release with req=1111, en=1 -> gnt=0001.
